// File: rtl/async_fifo_if.sv
// Handshake bundle between a single-clock FIFO and its producer/consumer.
// The master modport is the user side; the slave modport is the FIFO side.
interface fifo_intrf #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             rd_en;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wdata, rd_en,
        input  rdata, full, empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en,
        output rdata, full, empty, overflow, underflow
    );
endinterface

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data, full/empty flags and overflow/underflow reporting.
// Define ASYNC_FIFO_STICKY_ERR_EN to make overflow/underflow hold until reset.
module async_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic      wr_clk,
    input  logic      res,
    fifo_intrf.slave  bus
);
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH:0]   wptr_q, wptr_d;
    logic [PTR_WIDTH:0]   rptr_q, rptr_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 full_s, empty_s;
    logic                 wr_acc_s, rd_acc_s;

    // Flags are decoded purely from the registered pointers; the wrap bit separates full from empty.
    assign empty_s = (wptr_q == rptr_q);
    assign full_s  = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                     (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);

    assign bus.full      = full_s;
    assign bus.empty     = empty_s;
    assign bus.rdata     = rdata_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Next-state logic: acceptance uses the pre-edge flags, so a same-cycle read never frees room for a write.
    always_comb begin
        wr_acc_s    = bus.wr_en && !full_s;
        rd_acc_s    = bus.rd_en && !empty_s;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rdata_d     = rdata_q;
        if (wr_acc_s) begin
            wptr_d = wptr_q + {{PTR_WIDTH{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_acc_s) begin
            rptr_d  = rptr_q + {{PTR_WIDTH{1'b0}}, 1'b1};
            rdata_d = mem_q[rptr_q[PTR_WIDTH-1:0]];
        end else begin
            rptr_d  = rptr_q;
            rdata_d = rdata_q;
        end
`ifdef ASYNC_FIFO_STICKY_ERR_EN
        overflow_d  = overflow_q  || (bus.wr_en && full_s);
        underflow_d = underflow_q || (bus.rd_en && empty_s);
`else
        overflow_d  = bus.wr_en && full_s;
        underflow_d = bus.rd_en && empty_s;
`endif
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge wr_clk) begin
        if (!res) begin
            wptr_q      <= {(PTR_WIDTH+1){1'b0}};
            rptr_q      <= {(PTR_WIDTH+1){1'b0}};
            rdata_q     <= {WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; not cleared by reset, and writes are blocked during the reset cycle.
    always_ff @(posedge wr_clk) begin
        if (res && wr_acc_s) begin
            mem_q[wptr_q[PTR_WIDTH-1:0]] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: stimulus pushes expected read data into a queue,
// a negedge monitor pops and compares whenever a read was issued, and checks flags every cycle.
module tb_async_fifo;
    logic clk;
    logic res;
    int   errors = 0;
    int   checks = 0;

    fifo_intrf #(.WIDTH(8)) bus ();

    async_fifo #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4)) dut (
        .wr_clk (clk),
        .res    (res),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mq [$];      // model contents
    logic [7:0] exp_q [$];   // expected read data awaiting the monitor
    logic [7:0] last_rdata;
    logic       exp_ovf, exp_unf;
    logic       rd_check;
    logic       mon_en;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: flags every cycle, read data popped from the scoreboard when a read was issued.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("full",      {7'd0, bus.full},      {7'd0, (mq.size() == 16)});
            chk("empty",     {7'd0, bus.empty},     {7'd0, (mq.size() == 0)});
            chk("overflow",  {7'd0, bus.overflow},  {7'd0, exp_ovf});
            chk("underflow", {7'd0, bus.underflow}, {7'd0, exp_unf});
            if (rd_check) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: read flagged but queue empty at %0t", $time);
                end else begin
                    last_rdata = exp_q.pop_front();
                    chk("rdata", bus.rdata, last_rdata);
                end
                rd_check = 1'b0;
            end else begin
                chk("rdata_hold", bus.rdata, last_rdata);
            end
        end
    end

    task automatic cycle(input logic w, input logic [7:0] wd, input logic r);
        logic ful, emp;
        bus.wr_en = w;
        bus.wdata = wd;
        bus.rd_en = r;
        ful = (mq.size() == 16);
        emp = (mq.size() == 0);
        @(posedge clk);
        if (r && !emp) begin
            exp_q.push_back(mq.pop_front());
            rd_check = 1'b1;
        end
        if (w && !ful) mq.push_back(wd);
`ifdef ASYNC_FIFO_STICKY_ERR_EN
        exp_ovf = exp_ovf || (w && ful);
        exp_unf = exp_unf || (r && emp);
`else
        exp_ovf = w && ful;
        exp_unf = r && emp;
`endif
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        res       = 1'b0;
        bus.wr_en = 1'b1;   // requests during reset must be ignored
        bus.rd_en = 1'b1;
        bus.wdata = 8'h55;
        @(posedge clk);
        #1;
        res        = 1'b1;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        mq.delete();
        exp_q.delete();
        last_rdata = 8'h00;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
        rd_check   = 1'b0;
        mon_en     = 1'b1;
    endtask

    initial begin
        mon_en    = 1'b0;
        rd_check  = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wdata = 8'h00;
        res       = 1'b0;
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);

        // Fill, overflow attempt, then drain in order
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);

        // Underflow: rdata holds, then a write/read pair proves pointers stayed put
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h77, 1'b1);   // read rejected (empty before edge), write accepted
        cycle(1'b0, 8'h00, 1'b1);

        // Wrap and concurrent access
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h40, 1'b0);
        for (int i = 1; i <= 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Full with simultaneous read: write rejected, read accepted
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);

        // Mid-operation reset
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        do_reset();
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h99, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads never observed, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
